add3_pool_arbiter: RTL and testbench

ADD3_POOL_ARBITER -- requirements
Module: add3_pool_arbiter

---
 rtl/add3_pool_arbiter.sv | 120 ++++++++++++
 tb/tb_add3_pool_arbiter.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/add3_pool_arbiter.sv
// Two requesters share one 3-stage pipelined three-operand adder, with round-robin arbitration.
// Optional per-requester grant counters are compiled in when ADD3_POOL_ARBITER_PERF_EN is defined.
module add3_pool_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_x,
  input  logic [W-1:0] req0_y,
  input  logic [W-1:0] req0_z,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_x,
  input  logic [W-1:0] req1_y,
  input  logic [W-1:0] req1_z,
  output logic         req0_ready,
  output logic         req1_ready,
  output logic         res_valid,
  output logic         res_id,
  output logic [W-1:0] res_data,
  output logic         busy
`ifdef ADD3_POOL_ARBITER_PERF_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);

  logic         last_grant;
  logic         sel;
  logic         grant_en;
  logic         accept;

  logic         s0_valid;
  logic         s0_id;
  logic [W-1:0] s0_x;
  logic [W-1:0] s0_y;
  logic [W-1:0] s0_z;

  logic         s1_valid;
  logic         s1_id;
  logic [W-1:0] s1_sum;
  logic [W-1:0] s1_y;

  // On contention the requester that was not granted most recently wins.
  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_grant;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
    grant_en   = rst_n && !hold && (req0_valid || req1_valid);
    req0_ready = grant_en && !sel;
    req1_ready = grant_en && sel;
  end

  assign accept = req0_ready || req1_ready;

  // The result register counts as the last stage, so busy covers only the two stages before it.
  assign busy = s0_valid || s1_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      s0_valid   <= 1'b0;
      s0_id      <= 1'b0;
      s0_x       <= '0;
      s0_y       <= '0;
      s0_z       <= '0;
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s1_sum     <= '0;
      s1_y       <= '0;
      res_valid  <= 1'b0;
      res_id     <= 1'b0;
      res_data   <= '0;
    end else begin
      if (accept) begin
        last_grant <= sel;
      end

      s0_valid <= accept;
      if (accept) begin
        s0_id <= sel;
        s0_x  <= sel ? req1_x : req0_x;
        s0_y  <= sel ? req1_y : req0_y;
        s0_z  <= sel ? req1_z : req0_z;
      end

      s1_valid <= s0_valid;
      if (s0_valid) begin
        s1_id  <= s0_id;
        s1_sum <= s0_z + s0_x;
        s1_y   <= s0_y;
      end

      // The result id and data keep their previous value between completions.
      res_valid <= s1_valid;
      if (s1_valid) begin
        res_id   <= s1_id;
        res_data <= s1_sum + s1_y;
      end
    end
  end

`ifdef ADD3_POOL_ARBITER_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_ready) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_ready) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_add3_pool_arbiter.sv
// Directed self-checking bench for add3_pool_arbiter; counters checked when ADD3_POOL_ARBITER_PERF_EN is defined.
module tb_add3_pool_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         hold;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_x, req0_y, req0_z;
  logic [W-1:0] req1_x, req1_y, req1_z;
  logic         req0_ready, req1_ready;
  logic         res_valid, res_id, busy;
  logic [W-1:0] res_data;
`ifdef ADD3_POOL_ARBITER_PERF_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  int errors = 0;
  int checks = 0;

  add3_pool_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y), .req0_z(req0_z),
    .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y), .req1_z(req1_z),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data), .busy(busy)
`ifdef ADD3_POOL_ARBITER_PERF_EN
    , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Offer one op from requester rid alone, then follow it to the result three cycles later.
  task automatic single_op(input string tag, input logic rid, input logic [W-1:0] x,
                           input logic [W-1:0] y, input logic [W-1:0] z, input logic [W-1:0] exp);
    if (rid) begin
      req1_valid = 1'b1; req1_x = x; req1_y = y; req1_z = z;
    end else begin
      req0_valid = 1'b1; req0_x = x; req0_y = y; req0_z = z;
    end
    #1;
    check({tag, " ready0"}, req0_ready, !rid);
    check({tag, " ready1"}, req1_ready, rid);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check({tag, " busy c1"}, busy, 1'b1);
    check({tag, " res_valid c1"}, res_valid, 1'b0);
    tick();
    check({tag, " res_valid c2"}, res_valid, 1'b0);
    tick();
    check({tag, " res_valid c3"}, res_valid, 1'b1);
    check({tag, " res_id"}, res_id, rid);
    check({tag, " res_data"}, res_data, exp);
    check({tag, " busy c3"}, busy, 1'b0);
    tick();
    check({tag, " res_valid c4"}, res_valid, 1'b0);
    check({tag, " res_data held"}, res_data, exp);
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_x = '0; req0_y = '0; req0_z = '0;
    req1_x = '0; req1_y = '0; req1_z = '0;

    // Readies stay low during reset even with both requesters valid.
    tick();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("reset ready0", req0_ready, 1'b0);
    check("reset ready1", req1_ready, 1'b0);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("reset res_valid", res_valid, 1'b0);
    check("reset res_id", res_id, 1'b0);
    check("reset res_data", res_data, 32'h0);
    check("reset busy", busy, 1'b0);

    single_op("single", 1'b0, 32'd1, 32'd2, 32'd3, 32'd6);

    // Contention from reset: grants 0,1,0,1 and results in cycles 3..6.
    do_reset();
    req0_x = 32'd10;  req0_y = 32'd20;  req0_z = 32'd30;
    req1_x = 32'd100; req1_y = 32'd200; req1_z = 32'd300;
    for (int i = 0; i < 8; i++) begin
      req0_valid = (i < 4);
      req1_valid = (i < 4);
      #1;
      if (i < 4) begin
        check($sformatf("contend ready0 c%0d", i), req0_ready, (i % 2) == 0);
        check($sformatf("contend ready1 c%0d", i), req1_ready, (i % 2) == 1);
      end
      check($sformatf("contend res_valid c%0d", i), res_valid, (i >= 3 && i <= 6));
      if (i >= 3 && i <= 6) begin
        check($sformatf("contend res_id c%0d", i), res_id, ((i - 3) % 2) == 1);
        check($sformatf("contend res_data c%0d", i), res_data,
              ((i - 3) % 2) == 1 ? 64'd600 : 64'd60);
      end
      tick();
    end

    single_op("wrap", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0002, 32'h0000_0002);
    single_op("req1 only", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0005, 32'h0000_0005);

    // Hold: op accepted in cycle 0 completes in cycle 3; the held request resumes in cycle 5.
    req0_valid = 1'b1; req0_x = 32'd5; req0_y = 32'd6; req0_z = 32'd7;
    #1;
    check("hold ready0 c0", req0_ready, 1'b1);
    tick();
    hold = 1'b1;
    req0_x = 32'd1; req0_y = 32'd1; req0_z = 32'd1;
    for (int i = 1; i < 5; i++) begin
      #1;
      check($sformatf("hold ready0 c%0d", i), req0_ready, 1'b0);
      check($sformatf("hold busy c%0d", i), busy, i < 3);
      check($sformatf("hold res_valid c%0d", i), res_valid, i == 3);
      if (i == 3) check("hold res_data c3", res_data, 32'd18);
      tick();
    end
    hold = 1'b0;
    #1;
    check("hold resume ready0", req0_ready, 1'b1);
    tick();
    req0_valid = 1'b0;
    tick();
    tick();
    check("hold resume res_valid", res_valid, 1'b1);
    check("hold resume res_data", res_data, 32'd3);

    // Reset mid-flight; last grant was requester 0, reset must point contention back at 0.
    tick();
    req0_valid = 1'b1; req0_x = 32'd9; req0_y = 32'd9; req0_z = 32'd9;
    tick();
    req0_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("midreset res_valid c%0d", i), res_valid, 1'b0);
      check($sformatf("midreset busy c%0d", i), busy, 1'b0);
      tick();
    end
    check("midreset res_data", res_data, 32'h0);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("midreset contend ready0", req0_ready, 1'b1);
    check("midreset contend ready1", req1_ready, 1'b0);
    tick();
    // Requester 1 drops without a grant; requester 0 alone is granted, then 1 wins contention.
    req1_valid = 1'b0;
    #1;
    check("drop ready0", req0_ready, 1'b1);
    tick();
    req1_valid = 1'b1;
    #1;
    check("drop contend ready0", req0_ready, 1'b0);
    check("drop contend ready1", req1_ready, 1'b1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); tick(); tick();

`ifdef ADD3_POOL_ARBITER_PERF_EN
    do_reset();
    check("perf cnt0 reset", grant_cnt0, 16'd0);
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    req0_valid = 1'b0;
    check("perf cnt1", grant_cnt1, 16'd5);
    check("perf cnt0", grant_cnt0, 16'd3);
    tick(); tick(); tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
